// File: rtl/serial_alu.sv
// serial_alu: bit-serial ALU (AND / OR / ADD / SUB), one bit per clock, LSB first.
// Operands arrive over a valid/ready handshake in IDLE. The block shifts through
// WIDTH RUN cycles and presents a registered result with zero/carry/overflow
// flags in DONE until the consumer takes it.
module serial_alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             overflow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t           state;
  state_t           state_next;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [WIDTH-1:0] res_shifted;
  logic [1:0]       op_q;
  logic             c_q;
  logic [CW-1:0]    cnt;
  logic             zero_acc;

  logic             is_arith;
  logic             b_eff;
  logic             res_bit;
  logic             c_next;
  logic             last_bit;

  // Handshake signals come straight from the state register, never from inputs.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // State register; reset forces IDLE and overrides any pending in_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: accept in IDLE, run WIDTH bits, wait for the consumer in DONE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)  state_next = RUN;
      RUN:     if (last_bit)  state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // One-bit slice: the current bit of each operand is the LSB of its shift register.
  always_comb begin
    is_arith = op_q[1];
    b_eff    = b_sr[0] ^ (op_q == OP_SUB);
    c_next   = (a_sr[0] & b_eff) | (a_sr[0] & c_q) | (b_eff & c_q);
    case (op_q)
      OP_AND:  res_bit = a_sr[0] & b_sr[0];
      OP_OR:   res_bit = a_sr[0] | b_sr[0];
      default: res_bit = a_sr[0] ^ b_eff ^ c_q;
    endcase
    res_shifted = (res_sr >> 1) | {res_bit, {(WIDTH-1){1'b0}}};
    last_bit    = (cnt == CW'(WIDTH - 1));
  end

  // Datapath: load on accept, shift during RUN, publish result and flags on the last bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr     <= '0;
      b_sr     <= '0;
      res_sr   <= '0;
      op_q     <= 2'b00;
      c_q      <= 1'b0;
      cnt      <= '0;
      zero_acc <= 1'b0;
      result   <= '0;
      zero     <= 1'b0;
      carry    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sr     <= a;
            b_sr     <= b;
            op_q     <= op;
            c_q      <= (op == OP_SUB);
            cnt      <= '0;
            zero_acc <= 1'b1;
            res_sr   <= '0;
          end
        end
        RUN: begin
          a_sr     <= a_sr >> 1;
          b_sr     <= b_sr >> 1;
          res_sr   <= res_shifted;
          zero_acc <= zero_acc & ~res_bit;
          if (is_arith) begin
            c_q <= c_next;
          end
          if (last_bit) begin
            cnt      <= '0;
            result   <= res_shifted;
            zero     <= zero_acc & ~res_bit;
            carry    <= is_arith & c_next;
            overflow <= is_arith & (c_q ^ c_next);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
